byte_block_packer: RTL



---
 rtl/byte_block_packer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/byte_block_packer.sv
// Collects a stream of bytes into MSB-first blocks and hands each block to a consumer, with one block of output buffering.
// Optional drop counter (drop_count/drop_clr) is enabled by defining BYTE_BLOCK_PACKER_DROPCNT_EN.
module byte_block_packer #(
    parameter  int NUM_BITS  = 128,
    parameter  int NUM_IN    = 8,
    localparam int NUM_WORDS = NUM_BITS / NUM_IN,
    localparam int CW        = $clog2(NUM_WORDS) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_IN-1:0]   byte_in,
    input  logic                byte_valid,
    input  logic                byte_sof,
    output logic                byte_ready,
    output logic [NUM_BITS-1:0] block_out,
    output logic                block_valid,
    input  logic                block_ready,
    output logic [CW-1:0]       byte_count,
    output logic                partial_drop
`ifdef BYTE_BLOCK_PACKER_DROPCNT_EN
    ,
    input  logic                drop_clr,
    output logic [7:0]          drop_count
`endif
);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       count_q, count_d;
    logic [NUM_BITS-1:0] asm_q, asm_d;
    logic [NUM_BITS-1:0] block_out_q, block_out_d;
    logic                block_valid_q, block_valid_d;
    logic                partial_drop_q, partial_drop_d;

    logic                accept;
    logic                restart;
    logic                slot_free;
    logic                transfer;
    logic [NUM_WORDS-1:0] lane_we;

    assign byte_ready = (state_q == FILL);
    assign accept     = byte_valid & byte_ready;
    // A start-of-frame on a non-empty register throws away the partial block.
    assign restart    = accept & byte_sof & (count_q != '0);
    assign slot_free  = ~block_valid_q | block_ready;
    assign transfer   = (state_q == FULL) & slot_free;

    // One write enable per byte lane; a restart always targets the top lane.
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_lane
        assign lane_we[gi] = accept & (restart ? (gi == 0) : (count_q == CW'(gi)));
        assign asm_d[NUM_BITS-1-NUM_IN*gi -: NUM_IN] =
            lane_we[gi] ? byte_in : asm_q[NUM_BITS-1-NUM_IN*gi -: NUM_IN];
    end

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        block_out_d    = block_out_q;
        block_valid_d  = block_valid_q;
        partial_drop_d = 1'b0;

        if (transfer) begin
            block_out_d   = asm_q;
            block_valid_d = 1'b1;
            count_d       = '0;
            state_d       = FILL;
        end else if (block_valid_q && block_ready) begin
            block_valid_d = 1'b0;
        end

        // accept and transfer are mutually exclusive: one needs FILL, the other FULL.
        if (accept) begin
            if (restart) begin
                count_d        = CW'(1);
                partial_drop_d = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
                if (count_q == CW'(NUM_WORDS - 1)) begin
                    state_d = FULL;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= FILL;
            count_q        <= '0;
            asm_q          <= '1;
            block_out_q    <= '1;
            block_valid_q  <= 1'b0;
            partial_drop_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            asm_q          <= asm_d;
            block_out_q    <= block_out_d;
            block_valid_q  <= block_valid_d;
            partial_drop_q <= partial_drop_d;
        end
    end

    assign block_out    = block_out_q;
    assign block_valid  = block_valid_q;
    assign byte_count   = count_q;
    assign partial_drop = partial_drop_q;

`ifdef BYTE_BLOCK_PACKER_DROPCNT_EN
    logic [7:0] drop_count_q;

    // Counts on the same edge that raises partial_drop; clear wins over a coincident drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count_q <= '0;
        end else if (drop_clr) begin
            drop_count_q <= '0;
        end else if (partial_drop_d && (drop_count_q != 8'hFF)) begin
            drop_count_q <= drop_count_q + 8'd1;
        end
    end

    assign drop_count = drop_count_q;
`endif

endmodule
